// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I-subset main control FSM (fetch, decode, execute, memory, writeback).
// Define MULTICYCLE_CTRL_TRAP_EN to send illegal instructions to a sticky TRAP state instead of a NOP.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zeroFlag,
   input  logic       mem_ready,
   output logic [3:0] ALU_control,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       trap,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      TRAP     = 4'd15
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

`ifdef MULTICYCLE_CTRL_TRAP_EN
   localparam state_t ILL_NXT = TRAP;
`else
   localparam state_t ILL_NXT = FETCH;
`endif

   state_t cur, nxt, dec_nxt;
   logic alu_f3_ok, illegal;
   logic ir_w, pc_w, mem_w, reg_w;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cur <= FETCH;
      else cur <= nxt;

   // Illegal functs are rejected here so the EXEC states only ever see legal codes
   assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
   assign illegal = (opcode == OP_R || opcode == OP_I) ? !alu_f3_ok :
                    (opcode == OP_BR) ? (funct3 != 3'b000) :
                    !(opcode == OP_LW || opcode == OP_SW);
   assign dec_nxt = (opcode == OP_R) ? EXECR :
                    (opcode == OP_I) ? EXECI :
                    (opcode == OP_BR) ? BEQ : MEMADR;

   always_comb begin
      nxt = cur;
      ALU_control = ALU_AND;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      result_src = 2'd0;
      adr_src = 1'b0;
      ir_w = 1'b0;
      pc_w = 1'b0;
      mem_w = 1'b0;
      reg_w = 1'b0;
      case (cur)
         FETCH: begin
            alu_src_b = 2'd2;
            ALU_control = ALU_ADD;
            result_src = 2'd2;
            ir_w = mem_ready;
            pc_w = mem_ready;
            nxt = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            ALU_control = ALU_ADD;
            nxt = illegal ? ILL_NXT : dec_nxt;
         end
         MEMADR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            ALU_control = ALU_ADD;
            nxt = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            nxt = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            result_src = 2'd1;
            reg_w = 1'b1;
            nxt = FETCH;
         end
         MEMWRITE: begin
            adr_src = 1'b1;
            mem_w = 1'b1;
            nxt = mem_ready ? FETCH : MEMWRITE;
         end
         EXECR: begin
            alu_src_a = 2'd2;
            ALU_control = (funct3 == 3'b000) ? (funct7b5 ? ALU_SUB : ALU_ADD) :
                          (funct3 == 3'b110) ? ALU_OR : ALU_AND;
            nxt = ALUWB;
         end
         EXECI: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            ALU_control = (funct3 == 3'b000) ? ALU_ADD :
                          (funct3 == 3'b110) ? ALU_OR : ALU_AND;
            nxt = ALUWB;
         end
         ALUWB: begin
            reg_w = 1'b1;
            nxt = FETCH;
         end
         BEQ: begin
            alu_src_a = 2'd2;
            ALU_control = ALU_SUB;
            pc_w = zeroFlag;
            nxt = FETCH;
         end
         TRAP: nxt = ILL_NXT;
         default: nxt = FETCH;
      endcase
   end

   // Enables are gated by rst_n so an in-flight write is cut off the moment reset asserts
   assign ir_write = rst_n & ir_w;
   assign pc_write = rst_n & pc_w;
   assign mem_write = rst_n & mem_w;
   assign reg_write = rst_n & reg_w;
   assign state = cur;

`ifdef MULTICYCLE_CTRL_TRAP_EN
   assign trap = rst_n & (cur == TRAP);
`else
   assign trap = 1'b0;
`endif
endmodule
